// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: heartbeat-watched select sequencer for a 2:1 glitch-free clock mux (ports aclk/rst, hb_in1/2, sel_req handshake, selection, alive1/2, busy, done/err/failover pulses); define CLK_SEL_FAILOVER_EN for automatic failover
module clk_sel_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter bit RESET_SEL = 1'b0
) (
  input  logic aclk,
  input  logic rst,
  input  logic hb_in1,
  input  logic hb_in2,
  input  logic sel_req_valid,
  input  logic sel_req,
  output logic sel_req_ready,
  output logic selection,
  output logic alive1,
  output logic alive2,
  output logic busy,
  output logic switch_done,
  output logic switch_err,
  output logic failover
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES - 1);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state;
  logic [1:0] hb_s0, hb_s1, hb_d, hb_edge, alive;
  logic [1:0][CW-1:0] wd_cnt;
  logic [SW-1:0] settle_cnt;
  logic fo_fire, accept;
  assign hb_edge = hb_s1 ^ hb_d;
  assign alive1 = alive[0];
  assign alive2 = alive[1];
`ifdef CLK_SEL_FAILOVER_EN
  assign fo_fire = state == IDLE && !alive[selection] && alive[~selection];
`else
  assign fo_fire = 1'b0;
`endif
  assign sel_req_ready = state == IDLE && !fo_fire;
  assign accept = sel_req_valid && sel_req_ready;
  always_ff @(posedge aclk) begin
    if (rst) begin
      hb_s0 <= '0;
      hb_s1 <= '0;
      hb_d <= '0;
      alive <= '0;
      wd_cnt <= {2{TMAX}};
    end else begin
      hb_s0 <= {hb_in2, hb_in1};
      hb_s1 <= hb_s0;
      hb_d <= hb_s1;
      for (int i = 0; i < 2; i++) begin
        wd_cnt[i] <= hb_edge[i] ? '0 : wd_cnt[i] == TMAX ? TMAX : wd_cnt[i] + CW'(1);
        alive[i] <= wd_cnt[i] < TMAX;
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= IDLE;
      selection <= RESET_SEL;
      settle_cnt <= '0;
      busy <= 1'b0;
      switch_done <= 1'b0;
      switch_err <= 1'b0;
      failover <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      switch_err <= 1'b0;
      failover <= 1'b0;
      if (state == IDLE) begin
        if (fo_fire) begin
          selection <= ~selection;
          failover <= 1'b1;
          state <= SETTLE;
          busy <= 1'b1;
          settle_cnt <= SLOAD;
        end else if (accept) begin
          if (sel_req == selection) begin
            switch_done <= 1'b1;
          end else if (alive[sel_req]) begin
            selection <= sel_req;
            state <= SETTLE;
            busy <= 1'b1;
            settle_cnt <= SLOAD;
          end else begin
            switch_err <= 1'b1;
          end
        end
      end else if (settle_cnt == '0) begin
        state <= IDLE;
        busy <= 1'b0;
        switch_done <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt - SW'(1);
      end
    end
  end
endmodule
